// File: rtl/alu_mul_seq_if.sv
// Start/busy/done handshake between the control unit and the sequential multiplier.
interface alu_mul_seq_if;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start,
        output mcand,
        output mplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  mcand,
        input  mplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/alu_mul_seq.sv
// 8x8->16 unsigned shift-and-add multiplier that borrows the shared ALU adder.
// Optional feature: define MUL_ZERO_SKIP_EN to finish zero-operand multiplies in one cycle.
`ifndef OP_SUM
`define OP_SUM 3'd0
`endif

module alu_mul_seq (
    input  logic               clk,
    input  logic               rst_n,
    alu_mul_seq_if.slave       ctrl,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [2:0]         alu_op,
    input  logic [7:0]         alu_out,
    input  logic [7:0]         alu_flags
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  mc_q, mc_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic [15:0] step_acc;
    logic        zero_skip;
    logic        unused_flags;

    assign unused_flags = ^alu_flags[7:1];

`ifdef MUL_ZERO_SKIP_EN
    assign zero_skip = (ctrl.mcand == 8'd0) || (ctrl.mplier == 8'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // {carry, sum, lo} shifted right by one: carry becomes the new hi MSB.
    assign step_acc = {alu_flags[0], alu_out, lo_q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mc_q      <= 8'd0;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            cnt_q     <= 3'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_op    = `OP_SUM;

        unique case (state_q)
            StIdle: begin
                if (ctrl.start) begin
                    if (zero_skip) begin
                        product_d = 16'd0;
                        state_d   = StDone;
                    end else begin
                        mc_d    = ctrl.mcand;
                        lo_d    = ctrl.mplier;
                        hi_d    = 8'd0;
                        cnt_d   = 3'd0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? mc_q : 8'd0;
                {hi_d, lo_d} = step_acc;
                if (cnt_q == 3'd7) begin
                    product_d = step_acc;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ctrl.busy    = (state_q != StIdle);
    assign ctrl.done    = (state_q == StDone);
    assign ctrl.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus pushes expected products and done cycles,
// a negedge monitor compares every cycle against them.
`ifndef OP_SUM
`define OP_SUM 3'd0
`endif

module tb_alu_mul_seq;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out, alu_flags;
    logic [2:0] alu_op;
    logic [8:0] alu_sum;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_flags (alu_flags)
    );

    // Behavioural stand-in for the shared ALU adder.
    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_out   = alu_sum[7:0];
    assign alu_flags = {7'd0, alu_sum[8]};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          acc;
        int          done_cyc;
        int          run_hi;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          idle_at = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model_prod = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on the cycle its done is due.
    always @(negedge clk) begin
        logic exp_done, exp_busy, in_run;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        in_run   = 1'b0;
        if (rst_n && sb_q.size() > 0) begin
            exp_busy = (cyc >= sb_q[0].acc) && (cyc <= sb_q[0].done_cyc);
            in_run   = (cyc >= sb_q[0].acc) && (cyc <= sb_q[0].run_hi);
            if (sb_q[0].done_cyc == cyc) begin
                exp_done   = 1'b1;
                model_prod = sb_q[0].prod;
                void'(sb_q.pop_front());
            end
        end
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("product", 32'(bus.product), 32'(model_prod));
        check("alu_op", 32'(alu_op), 32'(`OP_SUM));
        if (!in_run) begin
            check("alu_a_idle", 32'(alu_a), 32'd0);
            check("alu_b_idle", 32'(alu_b), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request; the model decides whether and when the DUT accepts it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int   n, acc;
        exp_t e;
        bit   zero;
        n = cyc;
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        if (hold || (n + 1 >= idle_at)) begin
            acc        = (n + 1 > idle_at) ? n + 1 : idle_at;
            zero       = Skip && (a == 8'd0 || b == 8'd0);
            e.prod     = 16'(a) * 16'(b);
            e.acc      = acc;
            e.done_cyc = zero ? acc : acc + 8;
            e.run_hi   = zero ? acc - 1 : acc + 7;
            sb_q.push_back(e);
            idle_at = e.done_cyc + 2;
            while (cyc < acc) step();
        end else begin
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < idle_at) step();
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        sb_q.delete();
        model_prod = 16'd0;
        #1;
        check("busy_async_reset", 32'(bus.busy), 32'd0);
        check("product_async_reset", 32'(bus.product), 32'd0);
        repeat (cycles) step();
        rst_n   = 1'b1;
        idle_at = cyc + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start  = 1'b0;
        bus.mcand  = 8'd0;
        bus.mplier = 8'd0;
        repeat (3) step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_product", 32'(bus.product), 32'd0);
        rst_n   = 1'b1;
        idle_at = cyc + 1;

        issue(8'd13, 8'd11, 1'b0);
        wait_idle();
        check("p_13x11", 32'(bus.product), 32'h008F);

        issue(8'd255, 8'd255, 1'b0);
        wait_idle();
        check("p_255x255", 32'(bus.product), 32'hFE01);

        issue(8'd3, 8'd5, 1'b0);
        repeat (3) step();
        issue(8'd7, 8'd7, 1'b0);
        issue(8'd200, 8'd2, 1'b1);
        check("p_3x5", 32'(bus.product), 32'h000F);
        wait_idle();
        check("p_200x2", 32'(bus.product), 32'h0190);

        issue(8'd100, 8'd100, 1'b1);
        repeat (4) step();
        do_reset(2);
        check("p_after_reset", 32'(bus.product), 32'h0000);

        issue(8'd2, 8'd3, 1'b0);
        wait_idle();
        check("p_2x3", 32'(bus.product), 32'h0006);

        issue(8'd0, 8'd77, 1'b0);
        wait_idle();
        check("p_0x77", 32'(bus.product), 32'h0000);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) wait_idle();
            issue(a, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step();
        check("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
